sample_stream_buffer: RTL and testbench



---
 rtl/sample_stream_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/sample_stream_buffer.sv | 115 +++++++++++
 tb/tb_sample_stream_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_stream_pkg.sv
// Shared types and constants for the UART-to-DAC sample stream buffer.
package sample_stream_pkg;

    typedef enum logic {
        FILL,
        PLAY
    } play_state_t;

    typedef enum logic {
        LOW,
        HIGH
    } byte_phase_t;

    localparam logic [15:0] DEFAULT_IDLE_VALUE = 16'h8000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; occupancy comes from
// read/write counters that carry one extra MSB to tell full from empty.
module sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_count;
    logic [DEPTH_LOG2:0] rd_count;
    logic                do_write;
    logic                do_read;

    assign level    = wr_count - rd_count;
    assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_read  = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write = wr_en && (!full || do_read);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_count[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
            rd_count <= '0;
            rd_data  <= '0;
        end else begin
            if (do_write) begin
                wr_count <= wr_count + (DEPTH_LOG2+1)'(1);
            end
            if (do_read) begin
                rd_count <= rd_count + (DEPTH_LOG2+1)'(1);
                rd_data  <= mem[rd_count[DEPTH_LOG2-1:0]];
            end
        end
    end

endmodule

// File: rtl/sample_stream_buffer.sv
// Assembles little-endian 16-bit samples from UART bytes, buffers them and
// releases one per DAC tick once enough samples are prefilled.
module sample_stream_buffer
    import sample_stream_pkg::*;
#(
    parameter int              BITS       = 16,
    parameter int              DEPTH_LOG2 = 8,
    parameter int              PREFILL    = 128,
    parameter int              TIMEOUT    = 2048,
    parameter logic [BITS-1:0] IDLE_VALUE = DEFAULT_IDLE_VALUE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_received,
    input  logic                  sample_tick,
    output logic [BITS-1:0]       sample_out,
    output logic                  playing,
    output logic                  underrun,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    play_state_t      state;
    byte_phase_t      phase;
    logic [7:0]       low_byte;
    logic [CNT_W-1:0] idle_cnt;
    logic             show_fifo;
    logic [BITS-1:0]  fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_req;
    logic             rd_fire;

    assign wr_req  = rx_received && (phase == HIGH);
    assign rd_fire = sample_tick && (state == PLAY) && !fifo_empty;

    sync_fifo #(
        .WIDTH      (BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_req),
        .wr_data ({rx_byte, low_byte}),
        .rd_en   (rd_fire),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // A half-received sample left waiting for TIMEOUT cycles is abandoned,
    // so the next byte realigns as a low byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= LOW;
            low_byte <= '0;
            idle_cnt <= '0;
        end else if (rx_received) begin
            idle_cnt <= '0;
            if (phase == LOW) begin
                low_byte <= rx_byte;
                phase    <= HIGH;
            end else begin
                phase    <= LOW;
            end
        end else if (idle_cnt != CNT_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
            if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                phase <= LOW;
            end
        end
    end

    // show_fifo selects the FIFO read register; it stays set through an
    // underrun so the last sample holds until the FILL cycle clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FILL;
            show_fifo <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (wr_req && fifo_full && !rd_fire) begin
                overflow <= 1'b1;
            end
            case (state)
                FILL: begin
                    show_fifo <= 1'b0;
                    if (level >= (DEPTH_LOG2+1)'(PREFILL)) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (sample_tick) begin
                        if (fifo_empty) begin
                            underrun <= 1'b1;
                            state    <= FILL;
                        end else begin
                            show_fifo <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign sample_out = show_fifo ? fifo_rd_data : IDLE_VALUE;
    assign playing    = (state == PLAY);

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Scoreboard bench for sample_stream_buffer: a cycle model predicts FIFO
// contents and status, and every cycle's outputs are compared against it.
module tb_sample_stream_buffer;

    localparam int PREFILL   = 128;
    localparam int TIMEOUT   = 2048;
    localparam int FIFO_SIZE = 256;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_byte;
    logic        rx_received;
    logic        sample_tick;
    logic [15:0] sample_out;
    logic        playing;
    logic        underrun;
    logic        overflow;
    logic [8:0]  level;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    bit          m_high;
    bit          m_playing;
    bit          m_overflow;
    bit          m_show;
    logic [7:0]  m_low;
    logic [15:0] m_last;
    int          m_idle;

    sample_stream_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_byte     (rx_byte),
        .rx_received (rx_received),
        .sample_tick (sample_tick),
        .sample_out  (sample_out),
        .playing     (playing),
        .underrun    (underrun),
        .overflow    (overflow),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        m_high     = 1'b0;
        m_playing  = 1'b0;
        m_overflow = 1'b0;
        m_show     = 1'b0;
        m_low      = 8'h00;
        m_last     = 16'h0000;
        m_idle     = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sample_out"}, 32'(sample_out), 32'h8000);
        checkOutput({tag, "_playing"},    32'(playing),    32'd0);
        checkOutput({tag, "_underrun"},   32'(underrun),   32'd0);
        checkOutput({tag, "_overflow"},   32'(overflow),   32'd0);
        checkOutput({tag, "_level"},      32'(level),      32'd0);
    endtask

    // One clock cycle of stimulus; called at a falling edge, returns at the next.
    task automatic applyStimulus(input bit do_rx, input logic [7:0] b, input bit do_tick);
        bit          popped;
        bit          under;
        bit          play_pre;
        int          pre_size;
        logic [15:0] head;
        popped   = 1'b0;
        under    = 1'b0;
        head     = 16'h0000;
        play_pre = m_playing;
        pre_size = exp_q.size();

        rx_received = do_rx;
        rx_byte     = b;
        sample_tick = do_tick;

        if (do_tick && play_pre) begin
            if (exp_q.size() > 0) begin
                head   = exp_q.pop_front();
                popped = 1'b1;
            end else begin
                under  = 1'b1;
            end
        end
        if (do_rx) begin
            m_idle = 0;
            if (!m_high) begin
                m_low  = b;
                m_high = 1'b1;
            end else begin
                m_high = 1'b0;
                if (exp_q.size() < FIFO_SIZE) exp_q.push_back({b, m_low});
                else m_overflow = 1'b1;
            end
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
            if (m_idle == TIMEOUT) m_high = 1'b0;
        end
        if (play_pre) begin
            if (under) m_playing = 1'b0;
        end else if (pre_size >= PREFILL) begin
            m_playing = 1'b1;
        end
        if (!play_pre) begin
            m_show = 1'b0;
        end else if (popped) begin
            m_show = 1'b1;
            m_last = head;
        end

        @(negedge clk);
        checkOutput("level",      32'(level),      32'(exp_q.size()));
        checkOutput("playing",    32'(playing),    32'(m_playing));
        checkOutput("underrun",   32'(underrun),   32'(under));
        checkOutput("overflow",   32'(overflow),   32'(m_overflow));
        checkOutput("sample_out", 32'(sample_out), 32'(m_show ? m_last : 16'h8000));
        rx_received = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic sendPair(input logic [7:0] lo, input logic [7:0] hi);
        applyStimulus(1'b1, lo, 1'b0);
        applyStimulus(1'b1, hi, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        rx_byte     = 8'h00;
        rx_received = 1'b0;
        sample_tick = 1'b0;
        modelReset();
        #3;
        checkResetValues("reset");
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] prefill and first sample");
        for (int i = 0; i < PREFILL - 1; i++) sendPair(8'h34, 8'h12);
        applyStimulus(1'b0, 8'h00, 1'b1);
        sendPair(8'h34, 8'h12);
        checkOutput("prefill_not_yet_playing", 32'(playing), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("prefill_playing", 32'(playing), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("first_sample", 32'(sample_out), 32'h1234);
        checkOutput("first_level", 32'(level), 32'd127);

        $display("[TB] drain to underrun");
        while (exp_q.size() > 1) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("underrun_pulse", 32'(underrun), 32'd1);
        checkOutput("underrun_hold", 32'(sample_out), 32'h1234);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("underrun_idle", 32'(sample_out), 32'h8000);

        $display("[TB] byte phase resync");
        applyStimulus(1'b1, 8'hAA, 1'b0);
        repeat (TIMEOUT + 10) applyStimulus(1'b0, 8'h00, 1'b0);
        sendPair(8'h78, 8'h56);
        checkOutput("resync_level", 32'(level), 32'd1);
        for (int i = 1; i < PREFILL; i++) sendPair(8'(i), 8'(i ^ 8'h5A));
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("resync_sample", 32'(sample_out), 32'h5678);

        $display("[TB] full FIFO with concurrent read and write");
        for (int k = 0; exp_q.size() < FIFO_SIZE; k++) sendPair(8'(k * 3), 8'(8'hA0 + k));
        checkOutput("full_level", 32'(level), 32'd256);
        applyStimulus(1'b1, 8'h9C, 1'b0);
        applyStimulus(1'b1, 8'hE3, 1'b1);
        checkOutput("full_concurrent_level", 32'(level), 32'd256);
        checkOutput("full_concurrent_overflow", 32'(overflow), 32'd0);

        $display("[TB] overflow on full FIFO");
        sendPair(8'hDE, 8'hAD);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        checkOutput("overflow_level", 32'(level), 32'd256);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
        while (exp_q.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < PREFILL; i++) sendPair(8'(i + 7), 8'(8'h40 | i[5:0]));
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'hEF, 1'b0);
        checkOutput("post_reset_low_byte", 32'(level), 32'd0);
        applyStimulus(1'b1, 8'hBE, 1'b0);
        checkOutput("post_reset_pair", 32'(level), 32'd1);
        for (int i = 1; i < PREFILL; i++) sendPair(8'(i), 8'(~i));
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("post_reset_sample", 32'(sample_out), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
